// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module : vga_timing_pkg
// Brief  : 640x480@60 timing constants and the vertical-region encoding.
// Rev    : 1.0
// ============================================================================
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_TOTAL   = 800;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_TOTAL   = 525;

    localparam int unsigned c_h_sync_start = H_VISIBLE + H_FRONT;
    localparam int unsigned c_h_sync_end   = c_h_sync_start + H_SYNC;
    localparam int unsigned c_v_sync_start = V_VISIBLE + V_FRONT;
    localparam int unsigned c_v_sync_end   = c_v_sync_start + V_SYNC;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } v_region_t;

endpackage
`default_nettype wire

// File: rtl/vga_sync_generator_if.sv
`default_nettype none
// ============================================================================
// Module : vga_sync_generator_if
// Brief  : Horizontal-counter inputs and sync/pixel outputs of the generator.
// Rev    : 1.0
// ============================================================================
interface vga_sync_generator_if;

    logic       enable_v_counter;
    logic [9:0] h_count_value;
    logic [9:0] v_count_value;
    logic       hsync;
    logic       vsync;
    logic       video_active;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       line_start;
    logic       frame_start;
    logic [1:0] v_region;

    modport slave (
        input  enable_v_counter, h_count_value,
        output v_count_value, hsync, vsync, video_active,
               pixel_x, pixel_y, line_start, frame_start, v_region
    );

    modport master (
        output enable_v_counter, h_count_value,
        input  v_count_value, hsync, vsync, video_active,
               pixel_x, pixel_y, line_start, frame_start, v_region
    );

endinterface
`default_nettype wire

// File: rtl/vga_sync_generator_vertical_counter.sv
`default_nettype none
// ============================================================================
// Module : vertical_counter
// Brief  : Line counter advanced by the end-of-line strobe, wrapping per frame.
// Rev    : 1.0
// ============================================================================
module vertical_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned V_TOTAL = vga_timing_pkg::V_TOTAL
) (
    input  wire logic       pixel_clk,
    input  wire logic       reset,
    input  wire logic       i_enable,
    output logic      [9:0] o_v_next,
    output logic      [9:0] o_v_count
);

    localparam logic [9:0] c_v_last = 10'(V_TOTAL - 1);

    logic [9:0] r_v_count;
    logic [9:0] w_v_next;

    // Anything at or past the last line wraps, so a corrupted count self-heals.
    always_comb begin
        w_v_next = r_v_count;
        if (i_enable) begin
            w_v_next = (r_v_count >= c_v_last) ? 10'd0 : r_v_count + 10'd1;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            r_v_count <= 10'd0;
        end else begin
            r_v_count <= w_v_next;
        end
    end

    assign o_v_next  = w_v_next;
    assign o_v_count = r_v_count;

endmodule
`default_nettype wire

// File: rtl/vga_sync_generator.sv
`default_nettype none
// ============================================================================
// Module : vga_sync_generator
// Brief  : Vertical FSM plus registered sync, video-active and pixel outputs.
// Rev    : 1.0
// ============================================================================
module vga_sync_generator #(
    parameter int unsigned H_VISIBLE       = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT         = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC          = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_TOTAL         = vga_timing_pkg::H_TOTAL,
    parameter int unsigned V_VISIBLE       = vga_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT         = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC          = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_TOTAL         = vga_timing_pkg::V_TOTAL,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  wire logic           pixel_clk,
    input  wire logic           reset,
    vga_sync_generator_if.slave bus
);

    import vga_timing_pkg::*;

    localparam int unsigned c_hs_start = H_VISIBLE + H_FRONT;
    localparam int unsigned c_hs_end   = c_hs_start + H_SYNC;
    localparam int unsigned c_vs_start = V_VISIBLE + V_FRONT;
    localparam int unsigned c_vb_start = c_vs_start + V_SYNC;

    generate
        if (c_hs_end >= 1024 || H_TOTAL >= 1024 || c_vb_start >= 1024 || V_TOTAL >= 1024)
        begin : g_sum_check
            $error("vga_sync_generator: timing sums must fit in 10 bits");
        end
    endgenerate

    localparam logic [9:0] c_h_vis    = 10'(H_VISIBLE);
    localparam logic [9:0] c_h_hs_on  = 10'(c_hs_start);
    localparam logic [9:0] c_h_hs_off = 10'(c_hs_end);
    localparam logic [9:0] c_v_front  = 10'(V_VISIBLE);
    localparam logic [9:0] c_v_sync   = 10'(c_vs_start);
    localparam logic [9:0] c_v_back   = 10'(c_vb_start);
    localparam logic       c_sync_on  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic       c_sync_off = ~c_sync_on;

    logic [9:0] w_v_next;
    logic [9:0] w_v_count;
    v_region_t  r_region;
    v_region_t  w_next_region;
    logic       w_hsync_on;
    logic       w_video;

    vertical_counter #(
        .V_TOTAL (V_TOTAL)
    ) u_vertical_counter (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .i_enable  (bus.enable_v_counter),
        .o_v_next  (w_v_next),
        .o_v_count (w_v_count)
    );

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            r_region <= ACTIVE;
        end else begin
            r_region <= w_next_region;
        end
    end

    // Line 0 forces ACTIVE from any state so a disturbed FSM resyncs each frame.
    always_comb begin
        w_next_region = r_region;
        if (bus.enable_v_counter) begin
            if (w_v_next == 10'd0) begin
                w_next_region = ACTIVE;
            end else begin
                case (r_region)
                    ACTIVE:  if (w_v_next == c_v_front) w_next_region = FRONT;
                    FRONT:   if (w_v_next == c_v_sync)  w_next_region = SYNC;
                    SYNC:    if (w_v_next == c_v_back)  w_next_region = BACK;
                    default: w_next_region = r_region;
                endcase
            end
        end
    end

    assign w_hsync_on = (bus.h_count_value >= c_h_hs_on) && (bus.h_count_value < c_h_hs_off);
    assign w_video    = (bus.h_count_value < c_h_vis) && (w_next_region == ACTIVE);

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            bus.hsync        <= c_sync_off;
            bus.vsync        <= c_sync_off;
            bus.video_active <= 1'b0;
            bus.pixel_x      <= 10'd0;
            bus.pixel_y      <= 10'd0;
            bus.line_start   <= 1'b0;
            bus.frame_start  <= 1'b0;
        end else begin
            bus.hsync        <= w_hsync_on ? c_sync_on : c_sync_off;
            bus.vsync        <= (w_next_region == SYNC) ? c_sync_on : c_sync_off;
            bus.video_active <= w_video;
            bus.pixel_x      <= w_video ? bus.h_count_value : 10'd0;
            bus.pixel_y      <= w_video ? w_v_next : 10'd0;
            bus.line_start   <= (bus.h_count_value == 10'd0);
            bus.frame_start  <= (bus.h_count_value == 10'd0) && (w_v_next == 10'd0);
        end
    end

    assign bus.v_count_value = w_v_count;
    assign bus.v_region      = r_region;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_generator.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_sync_generator
// Brief  : Directed self-checking bench for vga_sync_generator.
// Rev    : 1.0
// ============================================================================
module tb_vga_sync_generator;

    logic pixel_clk = 1'b0;
    logic reset     = 1'b1;

    vga_sync_generator_if bus ();

    vga_sync_generator dut (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_pass  = 0;
    int n_total = 0;

    // Drive one h sample on the falling edge; outputs are read 1 ns after the rise.
    task automatic step(input int h, input logic en, input logic rst = 1'b0);
        @(negedge pixel_clk);
        reset                = rst;
        bus.h_count_value    = 10'(h);
        bus.enable_v_counter = en;
        @(posedge pixel_clk);
        #1;
    endtask

    function automatic logic [1:0] exp_region(input int v);
        if (v < 480)      return 2'd0;
        else if (v < 490) return 2'd1;
        else if (v < 492) return 2'd2;
        else              return 2'd3;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 5; i++) step(0, 1'b1, 1'b1);
        n_total++; if (bus.v_count_value !== 10'd0) $display("FAIL reset_v: got %0d want 0", bus.v_count_value); else n_pass++;
        n_total++; if (bus.hsync !== 1'b1) $display("FAIL reset_hsync: got %b want 1", bus.hsync); else n_pass++;
        n_total++; if (bus.vsync !== 1'b1) $display("FAIL reset_vsync: got %b want 1", bus.vsync); else n_pass++;
        n_total++; if (bus.video_active !== 1'b0) $display("FAIL reset_video: got %b want 0", bus.video_active); else n_pass++;
        n_total++; if (bus.line_start !== 1'b0) $display("FAIL reset_line_start: got %b want 0", bus.line_start); else n_pass++;
        n_total++; if (bus.frame_start !== 1'b0) $display("FAIL reset_frame_start: got %b want 0", bus.frame_start); else n_pass++;
        n_total++; if (bus.pixel_x !== 10'd0) $display("FAIL reset_pixel_x: got %0d want 0", bus.pixel_x); else n_pass++;
        n_total++; if (bus.pixel_y !== 10'd0) $display("FAIL reset_pixel_y: got %0d want 0", bus.pixel_y); else n_pass++;
        n_total++; if (bus.v_region !== 2'd0) $display("FAIL reset_region: got %0d want 0", bus.v_region); else n_pass++;
    endtask

    task automatic test_line();
        int hs_low   = 0;
        int hs_first = -1;
        int vid_cnt  = 0;
        logic       e_hs;
        logic       e_vid;
        logic [9:0] e_px;
        logic [9:0] e_py;
        for (int i = 0; i < 800; i++) begin
            step(i, (i == 0));
            e_hs  = (i >= 656 && i < 752) ? 1'b0 : 1'b1;
            e_vid = (i < 640);
            e_px  = e_vid ? 10'(i) : 10'd0;
            e_py  = e_vid ? 10'd1 : 10'd0;
            if (bus.hsync === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = i;
            end
            if (bus.video_active === 1'b1) vid_cnt++;
            n_total++; if (bus.hsync !== e_hs) $display("FAIL line_hsync h=%0d: got %b want %b", i, bus.hsync, e_hs); else n_pass++;
            n_total++; if (bus.video_active !== e_vid) $display("FAIL line_video h=%0d: got %b want %b", i, bus.video_active, e_vid); else n_pass++;
            n_total++; if (bus.pixel_x !== e_px) $display("FAIL line_pixel_x h=%0d: got %0d want %0d", i, bus.pixel_x, e_px); else n_pass++;
            n_total++; if (bus.pixel_y !== e_py) $display("FAIL line_pixel_y h=%0d: got %0d want %0d", i, bus.pixel_y, e_py); else n_pass++;
            n_total++; if (bus.line_start !== (i == 0)) $display("FAIL line_start h=%0d: got %b want %b", i, bus.line_start, (i == 0)); else n_pass++;
            n_total++; if (bus.frame_start !== 1'b0) $display("FAIL line_frame_start h=%0d: got %b want 0", i, bus.frame_start); else n_pass++;
            n_total++; if (bus.vsync !== 1'b1) $display("FAIL line_vsync h=%0d: got %b want 1", i, bus.vsync); else n_pass++;
            n_total++; if (bus.v_count_value !== 10'd1) $display("FAIL line_v h=%0d: got %0d want 1", i, bus.v_count_value); else n_pass++;
        end
        n_total++; if (hs_low != 96) $display("FAIL line_hsync_width: got %0d want 96", hs_low); else n_pass++;
        n_total++; if (hs_first != 656) $display("FAIL line_hsync_first: got %0d want 656", hs_first); else n_pass++;
        n_total++; if (vid_cnt != 640) $display("FAIL line_video_width: got %0d want 640", vid_cnt); else n_pass++;
    endtask

    task automatic test_frame();
        int ev       = 1;
        int fs_cnt   = 0;
        int vs_lines = 0;
        int vs_first = -1;
        int trans[4] = '{-1, -1, -1, -1};
        logic [1:0] prev = 2'd0;
        for (int n = 0; n < 525; n++) begin
            ev = (ev == 524) ? 0 : ev + 1;
            step(0, 1'b1);
            if (bus.frame_start === 1'b1) fs_cnt++;
            if (bus.vsync === 1'b0) begin
                vs_lines++;
                if (vs_first < 0) vs_first = ev;
            end
            if (bus.v_region !== prev) begin
                trans[bus.v_region] = ev;
                prev = bus.v_region;
            end
            n_total++; if (bus.v_count_value !== 10'(ev)) $display("FAIL frame_v: got %0d want %0d", bus.v_count_value, ev); else n_pass++;
            n_total++; if (bus.v_region !== exp_region(ev)) $display("FAIL frame_region v=%0d: got %0d want %0d", ev, bus.v_region, exp_region(ev)); else n_pass++;
            n_total++; if (bus.vsync !== ((ev == 490 || ev == 491) ? 1'b0 : 1'b1)) $display("FAIL frame_vsync v=%0d: got %b", ev, bus.vsync); else n_pass++;
            n_total++; if (bus.frame_start !== (ev == 0)) $display("FAIL frame_start v=%0d: got %b want %b", ev, bus.frame_start, (ev == 0)); else n_pass++;
            step(20, 1'b0);
            n_total++; if (bus.video_active !== (ev < 480)) $display("FAIL frame_video v=%0d: got %b want %b", ev, bus.video_active, (ev < 480)); else n_pass++;
            n_total++; if (bus.pixel_y !== ((ev < 480) ? 10'(ev) : 10'd0)) $display("FAIL frame_pixel_y v=%0d: got %0d", ev, bus.pixel_y); else n_pass++;
            step(700, 1'b0);
            n_total++; if (bus.hsync !== 1'b0) $display("FAIL frame_hsync v=%0d: got %b want 0", ev, bus.hsync); else n_pass++;
        end
        n_total++; if (fs_cnt != 1) $display("FAIL frame_start_count: got %0d want 1", fs_cnt); else n_pass++;
        n_total++; if (vs_lines != 2) $display("FAIL frame_vsync_lines: got %0d want 2", vs_lines); else n_pass++;
        n_total++; if (vs_first != 490) $display("FAIL frame_vsync_first: got %0d want 490", vs_first); else n_pass++;
        n_total++; if (trans[1] != 480) $display("FAIL frame_to_front: got %0d want 480", trans[1]); else n_pass++;
        n_total++; if (trans[2] != 490) $display("FAIL frame_to_sync: got %0d want 490", trans[2]); else n_pass++;
        n_total++; if (trans[3] != 492) $display("FAIL frame_to_back: got %0d want 492", trans[3]); else n_pass++;
        n_total++; if (trans[0] != 0) $display("FAIL frame_to_active: got %0d want 0", trans[0]); else n_pass++;
    endtask

    task automatic test_back_to_back_wrap();
        for (int n = 0; n < 523; n++) step(0, 1'b1);
        n_total++; if (bus.v_count_value !== 10'd524) $display("FAIL wrap_pre_v: got %0d want 524", bus.v_count_value); else n_pass++;
        n_total++; if (bus.v_region !== 2'd3) $display("FAIL wrap_pre_region: got %0d want 3", bus.v_region); else n_pass++;
        step(0, 1'b1);
        n_total++; if (bus.v_count_value !== 10'd0) $display("FAIL wrap_v: got %0d want 0", bus.v_count_value); else n_pass++;
        n_total++; if (bus.frame_start !== 1'b1) $display("FAIL wrap_frame_start: got %b want 1", bus.frame_start); else n_pass++;
        n_total++; if (bus.v_region !== 2'd0) $display("FAIL wrap_region: got %0d want 0", bus.v_region); else n_pass++;
        n_total++; if (bus.video_active !== 1'b1) $display("FAIL wrap_video: got %b want 1", bus.video_active); else n_pass++;
        n_total++; if (bus.pixel_y !== 10'd0) $display("FAIL wrap_pixel_y: got %0d want 0", bus.pixel_y); else n_pass++;
        step(1, 1'b0);
        n_total++; if (bus.frame_start !== 1'b0) $display("FAIL wrap_frame_start_clear: got %b want 0", bus.frame_start); else n_pass++;
        n_total++; if (bus.pixel_x !== 10'd1) $display("FAIL wrap_pixel_x: got %0d want 1", bus.pixel_x); else n_pass++;
        n_total++; if (bus.v_count_value !== 10'd0) $display("FAIL wrap_hold_v: got %0d want 0", bus.v_count_value); else n_pass++;
    endtask

    task automatic test_mid_reset();
        for (int n = 0; n < 300; n++) step(0, 1'b1);
        step(400, 1'b0);
        n_total++; if (bus.v_count_value !== 10'd300) $display("FAIL mid_pre_v: got %0d want 300", bus.v_count_value); else n_pass++;
        n_total++; if (bus.pixel_x !== 10'd400) $display("FAIL mid_pre_pixel_x: got %0d want 400", bus.pixel_x); else n_pass++;
        n_total++; if (bus.pixel_y !== 10'd300) $display("FAIL mid_pre_pixel_y: got %0d want 300", bus.pixel_y); else n_pass++;
        step(700, 1'b1, 1'b1);
        n_total++; if (bus.v_count_value !== 10'd0) $display("FAIL mid_rst_v: got %0d want 0", bus.v_count_value); else n_pass++;
        n_total++; if (bus.video_active !== 1'b0) $display("FAIL mid_rst_video: got %b want 0", bus.video_active); else n_pass++;
        n_total++; if (bus.hsync !== 1'b1) $display("FAIL mid_rst_hsync: got %b want 1", bus.hsync); else n_pass++;
        n_total++; if (bus.vsync !== 1'b1) $display("FAIL mid_rst_vsync: got %b want 1", bus.vsync); else n_pass++;
        step(402, 1'b0);
        n_total++; if (bus.v_count_value !== 10'd0) $display("FAIL mid_hold_v: got %0d want 0", bus.v_count_value); else n_pass++;
        n_total++; if (bus.video_active !== 1'b1) $display("FAIL mid_hold_video: got %b want 1", bus.video_active); else n_pass++;
        step(0, 1'b1);
        n_total++; if (bus.v_count_value !== 10'd1) $display("FAIL mid_post_v: got %0d want 1", bus.v_count_value); else n_pass++;
        n_total++; if (bus.line_start !== 1'b1) $display("FAIL mid_post_line_start: got %b want 1", bus.line_start); else n_pass++;
    endtask

    task automatic test_out_of_range();
        int hv[2] = '{900, 1023};
        for (int k = 0; k < 2; k++) begin
            step(hv[k], 1'b0);
            n_total++; if (bus.hsync !== 1'b1) $display("FAIL oor_hsync h=%0d: got %b want 1", hv[k], bus.hsync); else n_pass++;
            n_total++; if (bus.video_active !== 1'b0) $display("FAIL oor_video h=%0d: got %b want 0", hv[k], bus.video_active); else n_pass++;
            n_total++; if (bus.line_start !== 1'b0) $display("FAIL oor_line_start h=%0d: got %b want 0", hv[k], bus.line_start); else n_pass++;
            n_total++; if (bus.pixel_x !== 10'd0) $display("FAIL oor_pixel_x h=%0d: got %0d want 0", hv[k], bus.pixel_x); else n_pass++;
            n_total++; if (bus.v_count_value !== 10'd1) $display("FAIL oor_v h=%0d: got %0d want 1", hv[k], bus.v_count_value); else n_pass++;
        end
        step(900, 1'b1);
        n_total++; if (bus.v_count_value !== 10'd2) $display("FAIL oor_strobe_v: got %0d want 2", bus.v_count_value); else n_pass++;
        n_total++; if (bus.frame_start !== 1'b0) $display("FAIL oor_strobe_frame_start: got %b want 0", bus.frame_start); else n_pass++;
    endtask

    initial begin
        bus.h_count_value    = 10'd0;
        bus.enable_v_counter = 1'b0;
        test_reset();
        test_line();
        test_frame();
        test_back_to_back_wrap();
        test_mid_reset();
        test_out_of_range();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
